// File: rtl/rf_wb_pkg.sv
// Shared widths, FIFO payload type and helpers for the rf writeback unit.
// Register-file geometry mirrors the core configuration (RW, REGNO, REGNO_LOG).
package rf_wb_pkg;
    localparam int RW               = 32;
    localparam int REGNO            = 16;
    localparam int REGNO_LOG        = 4;
    localparam int RF_WB_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [REGNO_LOG-1:0] idx;
        logic [RW-1:0]        d;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_FIFO,
        SRC_MEM
    } wb_src_e;

    function automatic logic [REGNO-1:0] onehot(input logic [REGNO_LOG-1:0] idx);
        logic [REGNO-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/rf_wb_if.sv
// Bus bundle between execute/memory stages, rf_wb and the register file.
// Forwarding signals exist only when RF_WB_FWD_EN is defined.
interface rf_wb_if;
    import rf_wb_pkg::*;

    logic                 i_alu_we;
    logic [REGNO_LOG-1:0] i_alu_idx;
    logic [RW-1:0]        i_alu_d;
    logic                 i_ld_issue;
    logic [REGNO_LOG-1:0] i_ld_issue_idx;
    logic                 i_mem_valid;
    logic [REGNO_LOG-1:0] i_mem_idx;
    logic [RW-1:0]        i_mem_d;
    logic                 o_mem_ready;
    logic [REGNO-1:0]     o_rf_ie;
    logic                 o_rf_gie;
    logic [RW-1:0]        o_rf_d;
    logic [REGNO-1:0]     o_busy;
`ifdef RF_WB_FWD_EN
    logic                 o_fwd_valid;
    logic [REGNO_LOG-1:0] o_fwd_idx;
    logic [RW-1:0]        o_fwd_d;
`endif

    modport slave (
        input  i_alu_we, i_alu_idx, i_alu_d, i_ld_issue, i_ld_issue_idx,
        input  i_mem_valid, i_mem_idx, i_mem_d,
`ifdef RF_WB_FWD_EN
        output o_fwd_valid, o_fwd_idx, o_fwd_d,
`endif
        output o_mem_ready, o_rf_ie, o_rf_gie, o_rf_d, o_busy
    );

    modport master (
        output i_alu_we, i_alu_idx, i_alu_d, i_ld_issue, i_ld_issue_idx,
        output i_mem_valid, i_mem_idx, i_mem_d,
`ifdef RF_WB_FWD_EN
        input  o_fwd_valid, o_fwd_idx, o_fwd_d,
`endif
        input  o_mem_ready, o_rf_ie, o_rf_gie, o_rf_d, o_busy
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// wb_fifo: small in-order buffer for load results that lost arbitration.
// Caller guarantees no push when full and no pop when empty.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = RF_WB_FIFO_DEPTH
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  wb_entry_t i_din,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output wb_entry_t o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (i_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_din;
    end

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/rf_wb.sv
// rf_wb: arbitrates ALU and load-return writes onto the single rf write port
// and tracks outstanding loads. Optional forwarding outputs: RF_WB_FWD_EN.
module rf_wb
    import rf_wb_pkg::*;
#(
    parameter int WB_FIFO_DEPTH = RF_WB_FIFO_DEPTH
) (
    input logic    i_clk,
    input logic    i_rst,
    rf_wb_if.slave bus
);
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    wb_entry_t            fifo_head, mem_entry;
    logic                 mem_take;
    wb_src_e              src;
    logic [REGNO_LOG-1:0] wr_idx;
    logic [RW-1:0]        wr_d;
    logic                 wr_gie;
    logic [REGNO-1:0]     busy_q, busy_d;

    assign mem_entry = '{idx: bus.i_mem_idx, d: bus.i_mem_d};
    assign mem_take  = bus.i_mem_valid & ~fifo_full;
    // A returning load may only go direct when nothing is queued ahead of it.
    assign fifo_push = mem_take & (bus.i_alu_we | ~fifo_empty);
    assign fifo_pop  = ~fifo_empty & ~bus.i_alu_we;

    wb_fifo #(.DEPTH(WB_FIFO_DEPTH)) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (fifo_push),
        .i_din  (mem_entry),
        .i_pop  (fifo_pop),
        .o_full (fifo_full),
        .o_empty(fifo_empty),
        .o_head (fifo_head)
    );

    always_comb begin
        src    = SRC_NONE;
        wr_idx = '0;
        wr_d   = '0;
        if (bus.i_alu_we) begin
            src    = SRC_ALU;
            wr_idx = bus.i_alu_idx;
            wr_d   = bus.i_alu_d;
        end else if (!fifo_empty) begin
            src    = SRC_FIFO;
            wr_idx = fifo_head.idx;
            wr_d   = fifo_head.d;
        end else if (mem_take) begin
            src    = SRC_MEM;
            wr_idx = bus.i_mem_idx;
            wr_d   = bus.i_mem_d;
        end
    end

    assign wr_gie = (src != SRC_NONE) & ~i_rst;

    // Clear first, then set, so a re-issue to the retiring register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (src == SRC_FIFO || src == SRC_MEM) busy_d[wr_idx] = 1'b0;
        if (bus.i_ld_issue)                    busy_d[bus.i_ld_issue_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    assign bus.o_mem_ready = ~fifo_full;
    assign bus.o_rf_gie    = wr_gie;
    assign bus.o_rf_ie     = wr_gie ? onehot(wr_idx) : '0;
    assign bus.o_rf_d      = wr_d;
    assign bus.o_busy      = busy_q;

`ifdef RF_WB_FWD_EN
    assign bus.o_fwd_valid = wr_gie;
    assign bus.o_fwd_idx   = wr_idx;
    assign bus.o_fwd_d     = wr_d;
`endif
endmodule
